hex_display_scan: RTL and testbench



---
 rtl/hex_display_scan_if.sv | 47 ++++
 rtl/hex_display_scan.sv | 188 ++++++++++++++++++
 tb/tb_hex_display_scan.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_scan_if.sv
// hex_display_scan_if
//   Bundles the value-source side and the display-pin side of the
//   multiplexed hex display driver. Clock and reset are not part of the
//   bundle; they stay plain ports on the driver.
//
//   Signals:
//     i_value      [15:0] value to show, nibble [3:0] on digit 0 (rightmost)
//     i_dp         [3:0]  per-digit decimal point request, bit n -> digit n
//     i_blank_lz          1 = blank leading zero digits
//     o_seg        [6:0]  segments {g,f,e,d,c,b,a}, board polarity
//     o_dp                decimal point, board polarity
//     o_digit_sel  [3:0]  one-hot digit enable, board polarity
//     o_frame_done        one-cycle pulse after a new frame has been latched
//
//   Modports:
//     slave  - the display driver (consumes i_*, produces o_*)
//     master - the value source / board model (produces i_*, consumes o_*)

interface hex_display_scan_if;
    logic [15:0] i_value;
    logic [3:0]  i_dp;
    logic        i_blank_lz;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic [3:0]  o_digit_sel;
    logic        o_frame_done;

    modport slave (
        input  i_value,
        input  i_dp,
        input  i_blank_lz,
        output o_seg,
        output o_dp,
        output o_digit_sel,
        output o_frame_done
    );

    modport master (
        output i_value,
        output i_dp,
        output i_blank_lz,
        input  o_seg,
        input  o_dp,
        input  o_digit_sel,
        input  o_frame_done
    );
endinterface

// File: rtl/hex_display_scan.sv
// hex_display_scan
//   Multiplexed driver for a 4-digit 7-segment display. Shows a 16-bit value
//   as four hex digits, one digit per slot of SCAN_DIV clocks. Each slot
//   begins with BLANK_CYC clocks where every digit is off, which stops the
//   previous digit's segments from ghosting onto the next one. The input
//   value, decimal points and leading-zero mode are captured once per frame,
//   so a mid-frame change never mixes two values on the display.
//
//   Parameters:
//     SCAN_DIV        clocks per digit slot (>= 2)
//     BLANK_CYC       off clocks at the start of each slot (0 .. SCAN_DIV-1)
//     SEG_ACTIVE_LOW  1 = segment and dp pins are active-low
//     DIG_ACTIVE_LOW  1 = digit-select pins are active-low
//
//   Ports:
//     clk    clock
//     rst_n  asynchronous active-low reset; forces every output inactive
//     bus    hex_display_scan_if.slave (value inputs, display outputs)
//
//   All outputs are registered: what appears in cycle t+1 is derived from
//   the scan counters and shadow registers as they were in cycle t.

module hex_display_scan #(
    parameter int SCAN_DIV       = 50_000,
    parameter int BLANK_CYC      = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    hex_display_scan_if.slave  bus
);

    localparam int                CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  DIV_MAX = CNT_W'(SCAN_DIV - 1);

    // Inactive pin levels, used for reset and whenever nothing is lit.
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [3:0] SEL_OFF = DIG_ACTIVE_LOW ? 4'hF : 4'h0;

    // Scan position.
    logic [CNT_W-1:0] div_cnt;
    logic [1:0]       dig_idx;
    logic             tick;
    logic             frame_tick;
    logic             in_gap;

    // Per-frame copy of the inputs.
    logic [15:0]      shadow_val;
    logic [3:0]       shadow_dp;
    logic             shadow_lz;

    // Logical (active-high) view of the current digit.
    logic [3:0]       nibble;
    logic [3:0]       digit_onehot;
    logic [3:0]       lz_blank;
    logic [6:0]       seg_l;
    logic             dp_l;
    logic [3:0]       sel_l;

    // Output registers at board polarity.
    logic [6:0]       seg_q;
    logic             dp_q;
    logic [3:0]       sel_q;
    logic             frame_done_q;

    // Logical segment pattern for one hex nibble, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign tick       = (div_cnt == DIV_MAX);
    // The last tick of digit 3 both wraps dig_idx to 0 and captures the
    // inputs, so digit 0 of the new frame already sees the new shadow.
    assign frame_tick = tick && (dig_idx == 2'd3);

    // The anti-ghosting gap covers the first BLANK_CYC clocks of a slot.
    // With BLANK_CYC = 0 there is no gap, so the compare is left out rather
    // than being a compare against zero.
    generate
        if (BLANK_CYC == 0) begin : g_no_gap
            assign in_gap = 1'b0;
        end else begin : g_gap
            localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
            assign in_gap = (div_cnt < BLANK_LIM);
        end
    endgenerate

    // Slot divider and digit index. dig_idx is 2 bits, so it wraps 3 -> 0
    // by itself on the tick that ends digit 3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            dig_idx <= 2'd0;
        end else if (tick) begin
            div_cnt <= '0;
            dig_idx <= dig_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Frame latch: inputs are only looked at on the frame tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val <= 16'h0000;
            shadow_dp  <= 4'h0;
            shadow_lz  <= 1'b0;
        end else if (frame_tick) begin
            shadow_val <= bus.i_value;
            shadow_dp  <= bus.i_dp;
            shadow_lz  <= bus.i_blank_lz;
        end
    end

    // Leading-zero blanking per digit. A digit is blanked only when it and
    // every digit to its left are zero; digit 0 always shows, so the value
    // zero is displayed as a single '0'.
    always_comb begin
        lz_blank    = 4'b0000;
        lz_blank[3] = shadow_lz && (shadow_val[15:12] == 4'h0);
        lz_blank[2] = shadow_lz && (shadow_val[15:8]  == 8'h00);
        lz_blank[1] = shadow_lz && (shadow_val[15:4]  == 12'h000);
    end

    assign nibble       = shadow_val[{dig_idx, 2'b00} +: 4];
    assign digit_onehot = 4'b0001 << dig_idx;

    // Logical contents of the current slot. A blanked digit drops its
    // segments but keeps its decimal point, and stays enabled only when that
    // decimal point has to be lit. During the gap everything is off.
    always_comb begin
        seg_l = 7'h00;
        dp_l  = 1'b0;
        sel_l = 4'h0;
        if (!in_gap) begin
            dp_l = shadow_dp[dig_idx];
            if (!lz_blank[dig_idx]) begin
                seg_l = hex_to_seg(nibble);
                sel_l = digit_onehot;
            end else if (shadow_dp[dig_idx]) begin
                sel_l = digit_onehot;
            end
        end
    end

    // Output registers. Board polarity is applied here, as the very last
    // step, so the pins never see an intermediate combinational value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            sel_q        <= SEL_OFF;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_l ^ {7{SEG_ACTIVE_LOW}};
            dp_q         <= dp_l ^ SEG_ACTIVE_LOW;
            sel_q        <= sel_l ^ {4{DIG_ACTIVE_LOW}};
            frame_done_q <= frame_tick;
        end
    end

    assign bus.o_seg        = seg_q;
    assign bus.o_dp         = dp_q;
    assign bus.o_digit_sel  = sel_q;
    assign bus.o_frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// tb_hex_display_scan
//   Self-checking bench for hex_display_scan with SCAN_DIV=4, BLANK_CYC=1,
//   active-low segments and digits. A table of {inputs, expected frame}
//   records is driven one entry per frame; each expected frame is queued
//   when its inputs are driven and compared cycle by cycle once the DUT
//   signals that the frame has been latched. Hand-written sequences cover
//   reset, tear-free update and reset in the middle of a scan.

module tb_hex_display_scan;

    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 1;
    localparam int FRAME_CYC = 4 * SCAN_DIV;

    // Expected board-level contents of one frame, indexed by digit.
    typedef struct packed {
        logic [3:0][6:0] seg;
        logic [3:0][3:0] sel;
        logic [3:0]      dpo;
    } frame_t;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lz;
        frame_t      exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int num_checks = 0;
    int num_fails  = 0;

    frame_t sb_q[$];
    vec_t   vecs[10];
    frame_t zero_frame;
    frame_t f1234;
    frame_t fabcd;

    hex_display_scan_if bus();

    hex_display_scan #(
        .SCAN_DIV      (SCAN_DIV),
        .BLANK_CYC     (BLANK_CYC),
        .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [15:0] v, input logic [3:0] dp,
                                input logic lz, input logic [27:0] seg,
                                input logic [15:0] sel, input logic [3:0] dpo);
        vec_t r;
        r.value   = v;
        r.dp      = dp;
        r.lz      = lz;
        r.exp.seg = seg;
        r.exp.sel = sel;
        r.exp.dpo = dpo;
        return r;
    endfunction

    task automatic check_field(input string name, input int cyc,
                               input logic [6:0] actual, input logic [6:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, cyc, actual, expected);
        end
    endtask

    // Compare the 16 output cycles of one frame, starting at the next
    // falling edge. Cycle 1 is the gap of digit 0; the last cycle carries
    // the frame_done pulse of the following latch.
    task automatic check_slots(input frame_t f, input string tag);
        for (int c = 1; c <= FRAME_CYC; c++) begin
            int d;
            int ph;
            logic [6:0] es;
            logic [3:0] esel;
            logic       edp;
            @(negedge clk);
            d  = (c - 1) / SCAN_DIV;
            ph = (c - 1) % SCAN_DIV;
            if (ph < BLANK_CYC) begin
                es   = 7'h7F;
                esel = 4'hF;
                edp  = 1'b1;
            end else begin
                es   = f.seg[d];
                esel = f.sel[d];
                edp  = f.dpo[d];
            end
            check_field($sformatf("%s.seg", tag), c, bus.o_seg, es);
            check_field($sformatf("%s.sel", tag), c, 7'(bus.o_digit_sel), 7'(esel));
            check_field($sformatf("%s.dp", tag), c, 7'(bus.o_dp), 7'(edp));
            check_field($sformatf("%s.frame_done", tag), c, 7'(bus.o_frame_done),
                        (c == FRAME_CYC) ? 7'd1 : 7'd0);
        end
    endtask

    task automatic check_inactive(input string tag);
        check_field($sformatf("%s.seg", tag), 0, bus.o_seg, 7'h7F);
        check_field($sformatf("%s.sel", tag), 0, 7'(bus.o_digit_sel), 7'h0F);
        check_field($sformatf("%s.dp", tag), 0, 7'(bus.o_dp), 7'h01);
        check_field($sformatf("%s.frame_done", tag), 0, 7'(bus.o_frame_done), 7'h00);
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.i_value    = v.value;
        bus.i_dp       = v.dp;
        bus.i_blank_lz = v.lz;
        sb_q.push_back(v.exp);
    endtask

    // Wait (bounded) for the latch of the queued inputs, then compare the
    // frame that follows against the oldest queued expectation.
    task automatic checkOutput(input string tag);
        bit     seen;
        frame_t exp_f;
        seen = 1'b0;
        for (int i = 0; i < FRAME_CYC + 4 && !seen; i++) begin
            @(negedge clk);
            if (bus.o_frame_done === 1'b1) seen = 1'b1;
        end
        num_checks++;
        if (!seen) begin
            num_fails++;
            $display("[TB] FAIL %s.wait_frame_done: got no pulse within %0d cycles, expected one",
                     tag, FRAME_CYC + 4);
        end
        if (sb_q.size() == 0) begin
            num_checks++;
            num_fails++;
            $display("[TB] FAIL %s.scoreboard: got empty queue, expected an entry", tag);
        end else begin
            exp_f = sb_q.pop_front();
            if (seen) check_slots(exp_f, tag);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got simulation time %0t, expected end of test earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Table: value, dp, blank_lz, seg {d3,d2,d1,d0}, sel {d3..d0}, dp pins {d3..d0}
        vecs[0] = mk(16'h1234, 4'h0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 16'h7BDE, 4'hF);
        vecs[1] = mk(16'hABCD, 4'h0, 1'b0, {7'h08, 7'h03, 7'h46, 7'h21}, 16'h7BDE, 4'hF);
        vecs[2] = mk(16'h0005, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 16'hFFFE, 4'hF);
        vecs[3] = mk(16'h0000, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 16'hFFFE, 4'hF);
        vecs[4] = mk(16'h0F00, 4'h0, 1'b1, {7'h7F, 7'h0E, 7'h40, 7'h40}, 16'hFBDE, 4'hF);
        vecs[5] = mk(16'h0005, 4'b0100, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 16'hFBFE, 4'b1011);
        vecs[6] = mk(16'h89EF, 4'b1001, 1'b0, {7'h00, 7'h10, 7'h06, 7'h0E}, 16'h7BDE, 4'b0110);
        vecs[7] = mk(16'h0000, 4'h0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 16'h7BDE, 4'hF);
        vecs[8] = mk(16'h0070, 4'b0001, 1'b1, {7'h7F, 7'h7F, 7'h78, 7'h40}, 16'hFFDE, 4'b1110);
        vecs[9] = mk(16'h5006, 4'h0, 1'b1, {7'h12, 7'h40, 7'h40, 7'h02}, 16'h7BDE, 4'hF);

        zero_frame = mk(16'h0, 4'h0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 16'h7BDE, 4'hF).exp;
        f1234      = vecs[0].exp;
        fabcd      = vecs[1].exp;

        bus.i_value    = 16'h0000;
        bus.i_dp       = 4'h0;
        bus.i_blank_lz = 1'b0;
        rst_n          = 1'b0;

        // Reset held: everything inactive.
        repeat (3) @(negedge clk);
        check_inactive("reset_hold");

        // First frame after release shows '0' on every digit from the reset shadow.
        rst_n = 1'b1;
        check_slots(zero_frame, "post_reset");

        // Table-driven frames.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i));
        end

        // Tear-free: 1234 on screen, switch to ABCD while digit 1 is lit.
        $display("[TB] tear-free sequence");
        applyStimulus(vecs[0]);
        checkOutput("tear_setup");
        fork
            begin
                repeat (6) @(negedge clk);
                bus.i_value = 16'hABCD;
            end
        join_none
        check_slots(f1234, "tear_same_frame");
        check_slots(fabcd, "tear_next_frame");

        // Reset during the digit-2 slot while 1234 is displayed.
        $display("[TB] reset mid-scan sequence");
        applyStimulus(vecs[0]);
        checkOutput("rstmid_setup");
        repeat (10) @(negedge clk);
        check_field("rstmid.pre_sel", 10, 7'(bus.o_digit_sel), 7'h0B);
        check_field("rstmid.pre_seg", 10, bus.o_seg, 7'h24);
        rst_n = 1'b0;
        #1;
        check_inactive("rstmid_async");
        repeat (3) @(negedge clk);
        check_inactive("rstmid_hold");
        rst_n = 1'b1;
        check_slots(zero_frame, "rstmid_first");
        check_slots(f1234, "rstmid_second");

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
